uart_frame_decoder: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 15 +
 rtl/uart_frame_decoder_timeout.sv | 29 ++
 rtl/uart_frame_decoder.sv | 112 +++++++++++
 tb/tb_uart_frame_decoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame decoder: sync marker, FSM encoding and error codes.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/uart_frame_decoder_timeout.sv
// Inter-byte watchdog: counts idle cycles while a frame is open, flags expiry on the last count.
module frame_timeout #(
  parameter int TIMEOUT_CYC = 100000,
  parameter int TO_BIT      = 17
) (
  input  logic pclk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expire
);

  localparam logic [TO_BIT-1:0] LAST = TO_BIT'(TIMEOUT_CYC - 1);

  logic [TO_BIT-1:0] cnt;

  // A byte in the final cycle suppresses expiry.
  assign expire = run && !kick && (cnt == LAST);

  always_ff @(posedge pclk) begin
    if (rst)
      cnt <= '0;
    else if (kick || !run || expire)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// Assembles SYNC + payload + XOR checksum frames from the UART byte stream and
// publishes the last good payload with error flags and debug counters.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYC   = 100000,
  parameter int         TO_BIT        = 17
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [8*PAYLOAD_BYTES-1:0] frame_data,
  output logic                       frame_valid,
  output logic                       frame_err,
  output logic [1:0]                 err_code,
  output logic [7:0]                 good_cnt,
  output logic [7:0]                 err_cnt
);

  localparam int W = 8 * PAYLOAD_BYTES;

  state_t         state, state_nxt;
  logic [W-1:0]   shreg;
  logic [3:0]     idx;
  logic [7:0]     csum;
  logic           expire;
  logic           take_good, take_bad, take_to;

  frame_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_BIT      (TO_BIT)
  ) u_timeout (
    .pclk   (pclk),
    .rst    (rst),
    .run    (state != IDLE),
    .kick   (rx_valid),
    .expire (expire)
  );

  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_good = 1'b0;
    take_bad  = 1'b0;
    take_to   = 1'b0;
    case (state)
      IDLE:
        if (rx_valid && rx_data == SYNC_BYTE) state_nxt = PAYLOAD;
      PAYLOAD:
        if (rx_valid) begin
          if (idx == 4'(PAYLOAD_BYTES - 1)) state_nxt = CHECK;
        end else if (expire) begin
          take_to   = 1'b1;
          state_nxt = IDLE;
        end
      CHECK:
        if (rx_valid) begin
          take_good = (rx_data == csum);
          take_bad  = (rx_data != csum);
          state_nxt = IDLE;
        end else if (expire) begin
          take_to   = 1'b1;
          state_nxt = IDLE;
        end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      shreg       <= '0;
      idx         <= '0;
      csum        <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'b00;
      good_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= take_good;
      frame_err   <= take_bad | take_to;

      if (state == IDLE && rx_valid && rx_data == SYNC_BYTE) begin
        idx  <= '0;
        csum <= '0;
      end
      if (state == PAYLOAD && rx_valid) begin
        shreg <= (shreg << 8) | W'(rx_data);
        csum  <= csum ^ rx_data;
        idx   <= idx + 1'b1;
      end

      if (take_good) begin
        frame_data <= shreg;
        good_cnt   <= good_cnt + 1'b1;
      end
      if (take_bad || take_to) begin
        err_code <= take_bad ? ERR_CSUM : ERR_TIMEOUT;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: stimulus pushes expected pulses, a monitor pops and checks.
module tb_uart_frame_decoder;

  logic        pclk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] frame_data;
  logic        frame_valid, frame_err;
  logic [1:0]  err_code;
  logic [7:0]  good_cnt, err_cnt;

  uart_frame_decoder #(
    .PAYLOAD_BYTES (4),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYC   (100),
    .TO_BIT        (7)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .good_cnt    (good_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    logic [1:0]  code;
    logic [7:0]  good;
    logic [7:0]  err;
    int          at;
  } exp_t;

  exp_t        q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          last_cyc;
  logic [31:0] m_data = '0;
  logic [1:0]  m_code = 2'b00;
  logic [7:0]  m_good = '0;
  logic [7:0]  m_err  = '0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge pclk) begin
    if (rst === 1'b0 && (frame_valid || frame_err)) begin
      chk("valid_err_exclusive", {63'd0, frame_valid & frame_err}, 64'd0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {62'd0, frame_valid, frame_err}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", {63'd0, frame_err}, {63'd0, e.is_err});
        chk("frame_data", {32'd0, frame_data}, {32'd0, e.data});
        chk("good_cnt", {56'd0, good_cnt}, {56'd0, e.good});
        chk("err_cnt", {56'd0, err_cnt}, {56'd0, e.err});
        if (e.is_err) chk("err_code", {62'd0, err_code}, {62'd0, e.code});
        if (e.at >= 0) chk("pulse_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  // Called at a negedge; byte is sampled on the next posedge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    last_cyc = cyc + 1;
    @(negedge pclk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic push_good(input logic [31:0] d);
    exp_t e;
    m_data = d;
    m_good = m_good + 8'd1;
    e = '{1'b0, m_data, m_code, m_good, m_err, -1};
    q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code, input int at);
    exp_t e;
    m_code = code;
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
    e = '{1'b1, m_data, m_code, m_good, m_err, at};
    q.push_back(e);
  endtask

  task automatic send_frame(input logic [31:0] p, input logic [7:0] ck, input bit good);
    send(8'hA5);
    for (int i = 0; i < 4; i++) send(p[31-8*i -: 8]);
    if (good) push_good(p);
    else      push_err(2'b01, -1);
    send(ck);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge pclk);
      n++;
    end
    idle(2);
    chk(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    chk("rst_frame_data", {32'd0, frame_data}, 64'd0);
    chk("rst_pulses", {62'd0, frame_valid, frame_err}, 64'd0);
    chk("rst_err_code", {62'd0, err_code}, 64'd0);
    chk("rst_counts", {48'd0, good_cnt, err_cnt}, 64'd0);
    rst = 1'b0;
    idle(2);

    // 1: good frame
    send_frame(32'h12345678, 8'h08, 1'b1);
    drain("drain_good");
    // 2: bad checksum keeps old data
    send_frame(32'h12345678, 8'h09, 1'b0);
    drain("drain_bad_csum");
    // 3: idle garbage, then good frame
    send(8'h00); send(8'hFF); send(8'h5A);
    idle(5);
    chk("garbage_counts", {48'd0, good_cnt, err_cnt}, {48'd0, m_good, m_err});
    send_frame(32'h01020304, 8'h04, 1'b1);
    drain("drain_after_garbage");
    // 4: timeout 100 cycles after the last byte, then recovery
    send(8'hA5); send(8'h11); send(8'h22);
    push_err(2'b10, last_cyc + 100);
    drain("drain_timeout");
    send_frame(32'hAABBCCDD, 8'h00, 1'b1);
    drain("drain_after_timeout");
    // 5: sync byte as payload; byte landing on the expiry cycle
    send_frame(32'hA5A5A5A5, 8'h00, 1'b1);
    drain("drain_sync_data");
    send(8'hA5); send(8'h11);
    idle(99);
    send(8'h22); send(8'h33); send(8'h44);
    push_good(32'h11223344);
    send(8'h44);
    drain("drain_expiry_edge");

    // 6: good_cnt wraps, err_cnt saturates
    for (int i = 0; i < 256; i++) begin
      logic [31:0] p;
      p = {8'(i), 8'(i + 1), 8'(i * 3), 8'h5C};
      send_frame(p, p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0], 1'b1);
    end
    drain("drain_wrap");
    chk("good_cnt_wrapped", {56'd0, good_cnt}, {56'd0, m_good});
    for (int i = 0; i < 300; i++) send_frame(32'hDEADBEEF, 8'h00, 1'b0);
    drain("drain_saturate");
    chk("err_cnt_saturated", {56'd0, err_cnt}, 64'd255);

    // Reset mid-frame discards partial frame silently
    send(8'hA5); send(8'h12);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    m_data = '0; m_code = 2'b00; m_good = '0; m_err = '0;
    idle(3);
    chk("midrst_counts", {48'd0, good_cnt, err_cnt}, 64'd0);
    chk("midrst_frame_data", {32'd0, frame_data}, 64'd0);
    chk("midrst_err_code", {62'd0, err_code}, 64'd0);
    send_frame(32'hCAFE0102, 8'h37, 1'b1);
    drain("drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
